// File: rtl/exec_wb_arb_pkg.sv
// rtl/exec_wb_arb_pkg.sv - shared types and constants for the EX/FT writeback arbiter
package exec_wb_arb_pkg;

  typedef enum logic {SRC_EX = 1'b0, SRC_FT = 1'b1} wb_src_e;
  typedef enum logic {ST_EMPTY, ST_FULL} wb_state_e;

  localparam int PERF_CNT_W = 16;

endpackage

// File: rtl/wb_rr_pick.sv
// rtl/wb_rr_pick.sv - combinational 2-way round-robin picker (req[0]=EX, req[1]=FT)
module wb_rr_pick
  import exec_wb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  wb_src_e    last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // On contention the source that did not win last time takes the port.
    if (req == 2'b11) begin
      gnt = (last == SRC_FT) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/exec_wb_arbiter.sv
// rtl/exec_wb_arbiter.sv - EX/FT round-robin arbiter with a registered 1-entry WB stage
// Optional per-source grant counters under EXEC_WB_ARB_PERF_EN.
module exec_wb_arbiter
  import exec_wb_arb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter bit EX_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_data,
  output logic              ex_ready,
  input  logic              ft_valid,
  input  logic [DATA_W-1:0] ft_data,
  output logic              ft_ready,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_src,
  input  logic              wb_ready
`ifdef EXEC_WB_ARB_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] ex_grants,
  output logic [PERF_CNT_W-1:0] ft_grants
`endif
);

  wb_state_e         state_q, state_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  wb_src_e           wb_src_q, wb_src_d;
  wb_src_e           last_q, last_d;
  logic [1:0]        gnt;
  logic              load_en;
  logic              grant_ex;
  logic              grant_ft;

  wb_rr_pick u_pick (
    .req  ({ft_valid, ex_valid}),
    .last (last_q),
    .gnt  (gnt)
  );

  // The stage can take a new entry when empty or when the current one leaves this cycle.
  assign load_en  = (state_q == ST_EMPTY) | wb_ready;
  assign grant_ex = load_en & gnt[0];
  assign grant_ft = load_en & gnt[1];
  assign ex_ready = grant_ex;
  assign ft_ready = grant_ft;

  always_comb begin
    state_d   = state_q;
    wb_data_d = wb_data_q;
    wb_src_d  = wb_src_q;
    last_d    = last_q;
    if (grant_ex || grant_ft) begin
      state_d   = ST_FULL;
      wb_data_d = grant_ex ? ex_data : ft_data;
      wb_src_d  = grant_ex ? SRC_EX : SRC_FT;
      last_d    = grant_ex ? SRC_EX : SRC_FT;
    end else if (load_en) begin
      state_d = ST_EMPTY;
    end
  end

`ifdef EXEC_WB_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] ex_cnt_q, ex_cnt_d;
  logic [PERF_CNT_W-1:0] ft_cnt_q, ft_cnt_d;

  always_comb begin
    ex_cnt_d = ex_cnt_q;
    ft_cnt_d = ft_cnt_q;
    if (grant_ex && (ex_cnt_q != '1)) ex_cnt_d = ex_cnt_q + 1'b1;
    if (grant_ft && (ft_cnt_q != '1)) ft_cnt_d = ft_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_cnt_q <= '0;
      ft_cnt_q <= '0;
    end else begin
      ex_cnt_q <= ex_cnt_d;
      ft_cnt_q <= ft_cnt_d;
    end
  end

  assign ex_grants = ex_cnt_q;
  assign ft_grants = ft_cnt_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      wb_data_q <= '0;
      wb_src_q  <= SRC_EX;
      last_q    <= EX_FIRST ? SRC_FT : SRC_EX;
    end else begin
      state_q   <= state_d;
      wb_data_q <= wb_data_d;
      wb_src_q  <= wb_src_d;
      last_q    <= last_d;
    end
  end

  assign wb_valid = (state_q == ST_FULL);
  assign wb_data  = wb_data_q;
  assign wb_src   = wb_src_q;

endmodule

// File: tb/tb_exec_wb_arbiter.sv
// tb/tb_exec_wb_arbiter.sv - scoreboard bench for exec_wb_arbiter (EXEC_WB_ARB_PERF_EN optional)
module tb_exec_wb_arbiter;

  typedef struct packed {
    logic        src;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ft_valid, wb_ready;
  logic [31:0] ex_data, ft_data;
  logic        ex_ready, ft_ready;
  logic        wb_valid, wb_src;
  logic [31:0] wb_data;
`ifdef EXEC_WB_ARB_PERF_EN
  logic [15:0] ex_grants, ft_grants;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  ent_t        sb[$];
  logic        last_m;
  logic        obs_ex, obs_ft;
  logic [15:0] ex_cnt_m, ft_cnt_m;
  logic [31:0] held;

  always #5 clk = ~clk;

  exec_wb_arbiter #(.DATA_W(32), .EX_FIRST(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .ex_valid (ex_valid),
    .ex_data  (ex_data),
    .ex_ready (ex_ready),
    .ft_valid (ft_valid),
    .ft_data  (ft_data),
    .ft_ready (ft_ready),
    .wb_valid (wb_valid),
    .wb_data  (wb_data),
    .wb_src   (wb_src),
    .wb_ready (wb_ready)
`ifdef EXEC_WB_ARB_PERF_EN
    ,
    .ex_grants(ex_grants),
    .ft_grants(ft_grants)
`endif
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    sb.delete();
    last_m   = 1'b1;
    ex_cnt_m = '0;
    ft_cnt_m = '0;
  endfunction

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input logic ev, input logic [31:0] ed, input logic fv,
                       input logic [31:0] fd, input logic wr);
    logic ld, gex, gft;
    ent_t e;
    ex_valid = ev; ex_data = ed;
    ft_valid = fv; ft_data = fd;
    wb_ready = wr;
    #1;
    check("wb_valid", wb_valid, sb.size() != 0);
    if (sb.size() != 0 && wb_valid) begin
      check("wb_data", wb_data, sb[0].data);
      check("wb_src", wb_src, sb[0].src);
    end
    ld  = (sb.size() == 0) || wr;
    gex = ld && ev && (!fv || last_m == 1'b1);
    gft = ld && fv && (!ev || last_m == 1'b0);
    obs_ex = ex_ready;
    obs_ft = ft_ready;
    check("ex_ready", ex_ready, gex);
    check("ft_ready", ft_ready, gft);
    if (sb.size() != 0 && wr) void'(sb.pop_front());
    if (gex || gft) begin
      e.src  = gft;
      e.data = gex ? ed : fd;
      sb.push_back(e);
      last_m = gft;
      if (gex && ex_cnt_m != 16'hFFFF) ex_cnt_m = ex_cnt_m + 16'd1;
      if (gft && ft_cnt_m != 16'hFFFF) ft_cnt_m = ft_cnt_m + 16'd1;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ft_valid = 1'b0; wb_ready = 1'b0;
    ex_data = '0; ft_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_src", wb_src, 0);
    rst = 1'b0;

    // Contention: alternate EX, FT starting with EX
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 32'h100 + i, 1'b1, 32'h200 + i, 1'b1);
      check("contend_alt", obs_ex, (i % 2) == 0);
    end

    // Drain: entry leaves, data stays
    held = wb_data;
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    check("drain_valid", wb_valid, 0);
    check("drain_data", wb_data, held);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);

    // Lone FT requester, then contention goes to EX
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 32'hA0 + i, 1'b1);
    cycle(1'b1, 32'hE0, 1'b1, 32'hF0, 1'b1);
    check("lone_then_ex", obs_ex, 1);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);

    // Backpressure with 0x1234 held
    cycle(1'b1, 32'h1234, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h5555, 1'b1, 32'h6666, 1'b0);
    check("bp_hold", wb_data, 32'h1234);
    cycle(1'b1, 32'h5555, 1'b1, 32'h6666, 1'b1);
    check("bp_next_ft", obs_ft, 1);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);

    // Reset mid-transfer
    cycle(1'b0, '0, 1'b1, 32'hBEEF, 1'b0);
    cycle(1'b0, '0, 1'b0, '0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", wb_valid, 0);
    check("async_rst_data", wb_data, 0);
    check("async_rst_src", wb_src, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 32'h77, 1'b1, 32'h88, 1'b1);
    check("post_rst_ex_first", obs_ex, 1);

    // Random traffic
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 3) != 0));
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);

`ifdef EXEC_WB_ARB_PERF_EN
    for (int i = 0; i < 70000; i++) cycle(1'b1, i, 1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    check("ex_grants_sat", ex_grants, 16'hFFFF);
    check("ex_cnt_model", ex_cnt_m, 16'hFFFF);
    check("ft_grants", ft_grants, ft_cnt_m);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
